clkdiv_ctrl: RTL and testbench
==============================

# clkdiv_ctrl

Run-time controller for the programmable clock divider. It owns the divide ratio and the divider counter. It accepts ratio changes over a valid/ready handshake and applies them only at a period boundary, so the divided output never produces a runt pulse. It also gives the divided clock a graceful start and stop, and produces `clk_out` plus a one-cycle `tick` enable for downstream logic in the `clk` domain.

## Interface
- `WIDTH`, 16: width of the counter and divide ratio.
- `DEFAULT_DIV`, 4: divide ratio after reset. Must be ≥2; elaboration fails otherwise.
- `clk` in, 1: system clock. All logic is on the rising edge.
- `reset` in, 1: asynchronous, active-high reset.
- `enable` in, 1: start (1) or graceful stop (0) request.
- `cfg_valid` in, 1: new ratio offered.
- `cfg_div` in, WIDTH: offered ratio.
- `cfg_ready` out, 1: controller can accept a ratio.
- `clk_out` out, 1: divided clock, registered.
- `tick` out, 1: one-cycle pulse on the last cycle of each period, registered.
- `busy` out, 1: divider running (state ≠ IDLE).
- `err` out, 1: one-cycle pulse; an accepted ratio was illegal (<2).

## Operation
- Registers:
  - `state` ∈ {IDLE, RUN, STOP}
  - `count` (WIDTH)
  - `div_active` (WIDTH)
  - `pend_div` (WIDTH) with `pend_valid`
- Reset values: `state`=IDLE, `count`=0, `div_active`=DEFAULT_DIV, `pend_valid`=0, `clk_out`=0, `tick`=0, `err`=0, `cfg_ready`=1, `busy`=0.
- Handshake:
  - `cfg_ready` = !`pend_valid`.
  - A transfer occurs when `cfg_valid` && `cfg_ready`.
  - If `cfg_div` < 2: the value is discarded and `err` pulses the next cycle. The transfer still completes.
  - Legal value in IDLE: loaded directly into `div_active`.
  - Legal value in RUN/STOP: loaded into `pend_div`, and `pend_valid` is set.
- Wrap: the cycle where `count` == `div_active`−1 in RUN or STOP.
  - Next `count` = 0.
  - If `pend_valid`, `div_active` ← `pend_div` and `pend_valid` ← 0.
- Counting: in RUN/STOP, `count` increments by 1 each cycle except at wrap. In IDLE, `count` is held at 0.
- `clk_out`: high while `count` < H, low otherwise, where H = (`div_active`+1)>>1 (ceil). Odd ratios have the extra cycle high. In IDLE, `clk_out` is 0.
- `tick`: high exactly on the wrap cycle.
- State transitions:
  - IDLE → RUN when `enable`=1.
  - RUN → STOP when `enable`=0.
  - STOP → RUN when `enable`=1 before wrap; the period continues uninterrupted.
  - STOP → IDLE at wrap, when `enable`=0.
  - RUN stays in RUN at wrap.
- Simultaneous events:
  - Transfer on the wrap cycle: the value goes to pending and applies at the following wrap, not the current one.
  - Transfer while in IDLE on the same edge `enable` rises: the new ratio is used for the first period.
  - Pending ratio while stopping: applied at the final wrap, so IDLE holds the new `div_active`.
- Arithmetic: `count` never exceeds `div_active`−1. Ratios up to 2^WIDTH−1 are legal; there is no overflow path.

## Timing
- Start latency: `enable` sampled high at edge k gives `state`=RUN, `count`=0 and `clk_out`=1 in the cycle after edge k.
- Outputs are flops loaded from next-state decode, so `clk_out` and `tick` are aligned with `count`, not lagging it.
- `cfg_ready` drops in the cycle after a RUN-state transfer and rises in the cycle after the wrap that consumes the pending value.
- Period boundaries: the new ratio's first period starts at `count`=0, immediately after the wrap cycle.
- Stop: `busy` and `clk_out` go low in the cycle after the final `tick`. No partial periods are ever emitted.
- Reset mid-operation: all registers return to their reset values immediately (asynchronous), and any pending ratio is lost. The first edge after reset release behaves as IDLE.

## Test plan
All scenarios use WIDTH=8, DEFAULT_DIV=4.
1. Reset, then `enable`=1 → `clk_out` 1,1,0,0 repeating; `tick` high on every 4th cycle, coincident with `count`=3; `busy`=1.
2. RUN, transfer 6 at `count`=1 → `cfg_ready`=0 the next cycle; the current period ends after 4 cycles; the next period is 1,1,1,0,0,0 with `tick` on its 6th cycle; `cfg_ready`=1 after that wrap.
3. Transfer `cfg_div`=1, and separately 0 → `err` is a single-cycle pulse each time; `div_active` stays 4; period is unchanged.
4. RUN, `enable`→0 at `count`=1 → counts 2,3, `tick` pulses, then IDLE with `clk_out`=0, `busy`=0. Repeat with `enable`→1 at `count`=2 → stays in RUN with no gap in the period.
5. IDLE, transfer 5 with `enable`=1 on the same edge → first period is 1,1,1,0,0 with `tick` on cycle 5.
6. Assert `reset` mid-period with a pending ratio → all outputs go to reset values without waiting for an edge; after release and `enable`, the period is 4 again.

Source files
------------

// File: rtl/clkdiv_ctrl_if.sv
// rtl/clkdiv_ctrl_if.sv - divide-ratio configuration handshake for clkdiv_ctrl
interface clkdiv_ctrl_if #(
  parameter int WIDTH = 16
) ();
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready
  );
endinterface

// File: rtl/clkdiv_ctrl.sv
// rtl/clkdiv_ctrl.sv - programmable clock divider with glitch-free ratio change and graceful start/stop
// Ratio updates while running are parked in a pending slot and only take effect at a period boundary.
module clkdiv_ctrl #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  clkdiv_ctrl_if.slave cfg,
  output logic         clk_out,
  output logic         tick,
  output logic         busy,
  output logic         err
);

  if (DEFAULT_DIV < 2) begin : g_bad_default
    $error("clkdiv_ctrl: DEFAULT_DIV must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] count, count_n;
  logic [WIDTH-1:0] div_active, div_n;
  logic [WIDTH-1:0] pend_div, pend_div_n;
  logic             pend_valid, pend_valid_n;
  logic             clk_out_n, tick_n, err_n;
  logic             transfer, legal, wrap;
  logic [WIDTH:0]   high_len;

  assign cfg.cfg_ready = !pend_valid;
  assign busy          = (state != IDLE);

  always_comb begin
    state_n      = state;
    count_n      = count;
    div_n        = div_active;
    pend_div_n   = pend_div;
    pend_valid_n = pend_valid;
    transfer     = cfg.cfg_valid && !pend_valid;
    legal        = (cfg.cfg_div >= WIDTH'(2));
    wrap         = (state != IDLE) && (count == div_active - WIDTH'(1));

    case (state)
      IDLE:    if (enable) state_n = RUN;
      RUN:     if (!enable) state_n = STOP;
      STOP: begin
        if (enable)    state_n = RUN;
        else if (wrap) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (state == IDLE || wrap) count_n = '0;
    else                       count_n = count + WIDTH'(1);

    if (wrap && pend_valid) begin
      div_n        = pend_div;
      pend_valid_n = 1'b0;
    end

    // A transfer needs an empty pending slot, so it never collides with the swap above.
    if (transfer && legal) begin
      if (state == IDLE) begin
        div_n = cfg.cfg_div;
      end else begin
        pend_div_n   = cfg.cfg_div;
        pend_valid_n = 1'b1;
      end
    end

    err_n = transfer && !legal;

    // Outputs are decoded from next state so they line up with the count they describe.
    high_len  = ({1'b0, div_n} + (WIDTH+1)'(1)) >> 1;
    clk_out_n = (state_n != IDLE) && ({1'b0, count_n} < high_len);
    tick_n    = (state_n != IDLE) && (count_n == div_n - WIDTH'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      div_active <= WIDTH'(DEFAULT_DIV);
      pend_div   <= '0;
      pend_valid <= 1'b0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      div_active <= div_n;
      pend_div   <= pend_div_n;
      pend_valid <= pend_valid_n;
      clk_out    <= clk_out_n;
      tick       <= tick_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb/tb_clkdiv_ctrl.sv - directed vector bench for clkdiv_ctrl (WIDTH=8, DEFAULT_DIV=4)
module tb_clkdiv_ctrl;

  logic clk;
  logic reset;
  logic enable;
  logic clk_out, tick, busy, err;

  clkdiv_ctrl_if #(.WIDTH(8)) cfg_if ();

  clkdiv_ctrl #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .cfg     (cfg_if),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs packed as {clk_out, tick, busy, cfg_ready, err}.
  typedef struct {
    logic       en;
    logic       v;
    logic [7:0] d;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [4:0] outs();
    return {clk_out, tick, busy, cfg_if.cfg_ready, err};
  endfunction

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {clk_out,tick,busy,rdy,err}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic apply(input logic en, input logic v, input logic [7:0] d,
                       input logic [4:0] exp, input string name);
    enable           = en;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_div   = d;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  task automatic add(input logic en, input logic v, input logic [7:0] d, input logic [4:0] exp);
    vec_t r;
    r.en = en; r.v = v; r.d = d; r.exp = exp;
    vecs.push_back(r);
  endtask

  initial begin
    // start, period 4, then illegal ratios 1 and 0
    add(1,0,0,5'b10110); add(1,0,0,5'b10110); add(1,0,0,5'b00110); add(1,0,0,5'b01110);
    add(1,1,1,5'b10111); add(1,0,0,5'b10110); add(1,1,0,5'b00111); add(1,0,0,5'b01110);
    add(1,0,0,5'b10110); add(1,0,0,5'b10110);
    // ratio 6 offered at count=1
    add(1,1,6,5'b00100); add(1,0,0,5'b01100);
    add(1,0,0,5'b10110); add(1,0,0,5'b10110); add(1,0,0,5'b10110);
    add(1,0,0,5'b00110); add(1,0,0,5'b00110); add(1,0,0,5'b01110);
    add(1,0,0,5'b10110); add(1,0,0,5'b10110); add(1,0,0,5'b10110);
    add(1,0,0,5'b00110); add(1,0,0,5'b00110); add(1,0,0,5'b01110);
    // ratio 4 offered on the wrap cycle: applies one period later
    add(1,1,4,5'b10100); add(1,0,0,5'b10100); add(1,0,0,5'b10100);
    add(1,0,0,5'b00100); add(1,0,0,5'b00100); add(1,0,0,5'b01100);
    add(1,0,0,5'b10110); add(1,0,0,5'b10110);
    // graceful stop from count=1
    add(0,0,0,5'b00110); add(0,0,0,5'b01110); add(0,0,0,5'b00010); add(0,0,0,5'b00010);
    // stop request withdrawn before wrap
    add(1,0,0,5'b10110); add(1,0,0,5'b10110); add(0,0,0,5'b00110); add(1,0,0,5'b01110);
    add(1,0,0,5'b10110); add(1,0,0,5'b10110);
    add(0,0,0,5'b00110); add(0,0,0,5'b01110); add(0,0,0,5'b00010);
    // ratio 5 loaded in IDLE on the enable edge
    add(1,1,5,5'b10110); add(1,0,0,5'b10110); add(1,0,0,5'b10110);
    add(1,0,0,5'b00110); add(1,0,0,5'b01110); add(1,0,0,5'b10110);

    reset            = 1'b1;
    enable           = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 5'b00010);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i].en, vecs[i].v, vecs[i].d, vecs[i].exp, $sformatf("vec%0d", i));

    // pending ratio 3 offered while stopping: applied at the final wrap, kept in IDLE
    apply(0,1,3,5'b10100,"stop_pend_c1");
    apply(0,0,0,5'b10100,"stop_pend_c2");
    apply(0,0,0,5'b00100,"stop_pend_c3");
    apply(0,0,0,5'b01100,"stop_pend_wrap");
    apply(0,0,0,5'b00010,"stop_pend_idle");
    apply(1,0,0,5'b10110,"div3_c0");
    apply(1,0,0,5'b10110,"div3_c1");
    apply(1,0,0,5'b01110,"div3_c2");
    apply(1,0,0,5'b10110,"div3_next");

    // reset mid-period with ratio 7 pending
    apply(1,1,7,5'b10100,"pend7");
    cfg_if.cfg_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("async_reset", 5'b00010);
    @(posedge clk);
    #1;
    check("reset_held", 5'b00010);
    reset = 1'b0;
    apply(1,0,0,5'b10110,"post_rst_c0");
    apply(1,0,0,5'b10110,"post_rst_c1");
    apply(1,0,0,5'b00110,"post_rst_c2");
    apply(1,0,0,5'b01110,"post_rst_c3");
    apply(1,0,0,5'b10110,"post_rst_next");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
